// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised event/timebase counter.
// Mode encodings and a ceiling-log2 helper used to size prescaler widths.
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // Smallest bit count able to hold n distinct states (at least 1).
   function automatic int clog2(input int n);
      int bits;
      int rem;
      bits = 0;
      rem  = n - 1;
      while (rem > 0) begin
         bits++;
         rem = rem >> 1;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits a tick once every PRESCALE enabled cycles.
// A restart returns the phase to zero so a clear/load starts a fresh period.
module counter_prescaler #(
   parameter int PRESCALE = 1,
   parameter int PS_WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

   logic [PS_WIDTH-1:0] ps;

   // Phase only advances while enabled, so gaps in en stretch the period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps <= '0;
      end else if (restart) begin
         ps <= '0;
      end else if (en) begin
         ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
      end
   end

   assign tick = en & (ps == PS_LAST);

endmodule

// File: rtl/counter_mod.sv
// Parametrised up/down counter with clear, clamped load, prescaled stepping,
// wrap or saturate at the limits, a terminal-count pulse and a sticky flag.
module counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MODULUS  = 256,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1,
   parameter int PS_WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             tc,
   output logic             ovf
);

   // One extra bit so MODULUS == 2**WIDTH still yields a representable limit.
   localparam logic [WIDTH:0]   MOD_MAX = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] VAL_MAX = MOD_MAX[WIDTH-1:0];

   logic             tick;
   logic             at_max;
   logic             at_zero;
   logic             load_over;
   logic [WIDTH-1:0] value_next;
   logic             tc_next;
   logic             ovf_next;

   counter_prescaler #(
      .PRESCALE (PRESCALE),
      .PS_WIDTH (PS_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .restart (clear | load),
      .tick    (tick)
   );

   assign at_max    = ({1'b0, value} == MOD_MAX);
   assign at_zero   = (value == '0);
   assign load_over = ({1'b0, load_val} > MOD_MAX);

   // Priority is clear, then load, then a prescaled step; a load swallows a coincident tick.
   always_comb begin
      value_next = value;
      tc_next    = 1'b0;
      ovf_next   = ovf;
      if (clear) begin
         value_next = '0;
         ovf_next   = 1'b0;
      end else if (load) begin
         value_next = load_over ? VAL_MAX : load_val;
      end else if (tick) begin
         if (up_dn) begin
            if (at_max) begin
               value_next = (SATURATE == CNT_SAT) ? value : '0;
               tc_next    = 1'b1;
               ovf_next   = 1'b1;
            end else begin
               value_next = value + 1'b1;
            end
         end else begin
            if (at_zero) begin
               value_next = (SATURATE == CNT_SAT) ? value : VAL_MAX;
               tc_next    = 1'b1;
               ovf_next   = 1'b1;
            end else begin
               value_next = value - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         value <= value_next;
         tc    <= tc_next;
         ovf   <= ovf_next;
      end
   end

endmodule

// File: tb/tb_counter_mod.sv
// Directed scoreboard bench for counter_mod across four parameter sets:
// defaults, modulus-10 wrap, modulus-10 saturate and prescale-by-4.
module tb_counter_mod;

   logic       clk;
   logic       reset;
   logic       en       [4];
   logic       up_dn    [4];
   logic       clear    [4];
   logic       load     [4];
   logic [7:0] load_val [4];
   logic [7:0] value    [4];
   logic       tc       [4];
   logic       ovf      [4];

   typedef struct {
      int         inst;
      logic [7:0] value;
      logic       tc;
      logic       ovf;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   counter_mod #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .PRESCALE(1), .PS_WIDTH(8)) u_dflt (
      .clk(clk), .reset(reset), .en(en[0]), .up_dn(up_dn[0]), .clear(clear[0]),
      .load(load[0]), .load_val(load_val[0]), .value(value[0]), .tc(tc[0]), .ovf(ovf[0]));

   counter_mod #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .PRESCALE(1), .PS_WIDTH(8)) u_mod10 (
      .clk(clk), .reset(reset), .en(en[1]), .up_dn(up_dn[1]), .clear(clear[1]),
      .load(load[1]), .load_val(load_val[1]), .value(value[1]), .tc(tc[1]), .ovf(ovf[1]));

   counter_mod #(.WIDTH(8), .MODULUS(10), .SATURATE(1), .PRESCALE(1), .PS_WIDTH(8)) u_sat10 (
      .clk(clk), .reset(reset), .en(en[2]), .up_dn(up_dn[2]), .clear(clear[2]),
      .load(load[2]), .load_val(load_val[2]), .value(value[2]), .tc(tc[2]), .ovf(ovf[2]));

   counter_mod #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .PRESCALE(4), .PS_WIDTH(8)) u_ps4 (
      .clk(clk), .reset(reset), .en(en[3]), .up_dn(up_dn[3]), .clear(clear[3]),
      .load(load[3]), .load_val(load_val[3]), .value(value[3]), .tc(tc[3]), .ovf(ovf[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input int i, input logic e, input logic ud, input logic c,
                                 input logic l, input logic [7:0] lv);
      en[i]       = e;
      up_dn[i]    = ud;
      clear[i]    = c;
      load[i]     = l;
      load_val[i] = lv;
   endtask

   task automatic expect_out(input int i, input logic [7:0] v, input logic t, input logic o,
                             input string tag);
      exp_t x;
      x.inst  = i;
      x.value = v;
      x.tc    = t;
      x.ovf   = o;
      x.tag   = tag;
      sb.push_back(x);
   endtask

   // Drains every queued expectation, optionally after the next rising edge.
   task automatic check_output(input bit at_edge);
      exp_t x;
      if (at_edge) begin
         @(posedge clk);
         #1;
      end
      while (sb.size() > 0) begin
         x = sb.pop_front();
         tests_run++;
         assert (value[x.inst] === x.value) else begin
            tests_failed++;
            $error("FAIL %s value inst%0d: got %0h expected %0h", x.tag, x.inst, value[x.inst], x.value);
         end
         tests_run++;
         assert (tc[x.inst] === x.tc) else begin
            tests_failed++;
            $error("FAIL %s tc inst%0d: got %0b expected %0b", x.tag, x.inst, tc[x.inst], x.tc);
         end
         tests_run++;
         assert (ovf[x.inst] === x.ovf) else begin
            tests_failed++;
            $error("FAIL %s ovf inst%0d: got %0b expected %0b", x.tag, x.inst, ovf[x.inst], x.ovf);
         end
      end
   endtask

   task automatic step(input int i, input logic e, input logic ud, input logic c, input logic l,
                       input logic [7:0] lv, input logic [7:0] v, input logic t, input logic o,
                       input string tag);
      apply_stimulus(i, e, ud, c, l, lv);
      expect_out(i, v, t, o, tag);
      check_output(1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish by time limit, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 4; i++) apply_stimulus(i, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      #12;
      for (int i = 0; i < 4; i++) expect_out(i, 8'h00, 1'b0, 1'b0, "reset");
      check_output(1'b0);
      reset = 1'b1;

      // Default instance: wrap through 0xFF.
      step(0, 1, 1, 0, 1, 8'hFD, 8'hFD, 0, 0, "load_fd");
      step(0, 1, 1, 0, 0, 8'h00, 8'hFE, 0, 0, "up_fe");
      step(0, 1, 1, 0, 0, 8'h00, 8'hFF, 0, 0, "up_ff");
      step(0, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, "wrap_00");
      step(0, 1, 1, 0, 0, 8'h00, 8'h01, 0, 1, "after_wrap");
      step(0, 1, 1, 0, 0, 8'h00, 8'h02, 0, 1, "cnt_02");

      // Asynchronous reset between edges, held across one edge.
      #3;
      reset = 1'b0;
      #1;
      expect_out(0, 8'h00, 0, 0, "async_rst");
      check_output(1'b0);
      #8;
      expect_out(0, 8'h00, 0, 0, "rst_hold");
      check_output(1'b0);
      reset = 1'b1;
      step(0, 1, 1, 0, 0, 8'h00, 8'h01, 0, 0, "resume_1");
      step(0, 1, 1, 0, 0, 8'h00, 8'h02, 0, 0, "resume_2");

      // Priority among clear, load and tick.
      step(0, 1, 1, 1, 1, 8'h05, 8'h00, 0, 0, "clr_over_load");
      step(0, 1, 1, 0, 1, 8'h05, 8'h05, 0, 0, "load_over_tick");
      step(0, 1, 1, 0, 1, 8'hFF, 8'hFF, 0, 0, "load_ff_tick");
      step(0, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1, "wrap_again");
      step(0, 1, 1, 0, 1, 8'h10, 8'h10, 0, 1, "load_keeps_ovf");
      step(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, "clear_ovf");
      apply_stimulus(0, 0, 0, 0, 0, 8'h00);

      // Modulus 10, counting down with wrap and load clamp.
      step(1, 0, 0, 0, 1, 8'd3,  8'd3, 0, 0, "m10_load3");
      step(1, 1, 0, 0, 0, 8'd0,  8'd2, 0, 0, "m10_dn2");
      step(1, 1, 0, 0, 0, 8'd0,  8'd1, 0, 0, "m10_dn1");
      step(1, 1, 0, 0, 0, 8'd0,  8'd0, 0, 0, "m10_dn0");
      step(1, 1, 0, 0, 0, 8'd0,  8'd9, 1, 1, "m10_wrap9");
      step(1, 1, 0, 0, 0, 8'd0,  8'd8, 0, 1, "m10_dn8");
      step(1, 0, 0, 0, 1, 8'd15, 8'd9, 0, 1, "m10_clamp");
      apply_stimulus(1, 0, 0, 0, 0, 8'h00);

      // Modulus 10, saturating at both limits.
      step(2, 0, 1, 0, 1, 8'd8, 8'd8, 0, 0, "sat_load8");
      step(2, 1, 1, 0, 0, 8'd0, 8'd9, 0, 0, "sat_up9");
      step(2, 1, 1, 0, 0, 8'd0, 8'd9, 1, 1, "sat_hold1");
      step(2, 1, 1, 0, 0, 8'd0, 8'd9, 1, 1, "sat_hold2");
      step(2, 1, 1, 0, 0, 8'd0, 8'd9, 1, 1, "sat_hold3");
      step(2, 0, 1, 0, 0, 8'd0, 8'd9, 0, 1, "sat_idle");
      step(2, 0, 1, 1, 0, 8'd0, 8'd0, 0, 0, "sat_clear");
      step(2, 1, 0, 0, 0, 8'd0, 8'd0, 1, 1, "sat_floor");
      apply_stimulus(2, 0, 0, 0, 0, 8'h00);

      // Prescale by 4: one step per four enabled cycles, paused for three.
      for (int k = 0; k < 9; k++)
         step(3, 1, 1, 0, 0, 8'd0, 8'((k + 1) / 4), 0, 0, "ps_run");
      for (int k = 0; k < 3; k++)
         step(3, 0, 1, 0, 0, 8'd0, 8'd2, 0, 0, "ps_paused");
      for (int k = 9; k < 12; k++)
         step(3, 1, 1, 0, 0, 8'd0, 8'((k + 1) / 4), 0, 0, "ps_resume");
      apply_stimulus(3, 0, 0, 0, 0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
